// File: rtl/mem_1rw_pkg.sv
// mem_1rw_pkg: widths, types and constants shared by the mem_1rw request-side arbiter
// and its response FIFO.
package mem_1rw_pkg;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 64;
  localparam int RSP_DEPTH = 2;
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_W    = 2'd1,
    GRANT_R    = 2'd2
  } grant_e;

  typedef enum logic {
    PRIO_R = 1'b0,
    PRIO_W = 1'b1
  } prio_e;

  // A read may issue only if its response is guaranteed a FIFO slot when it returns.
  function automatic logic hasCredit(input logic [CNT_W-1:0] count,
                                     input logic             inflight,
                                     input logic             popping);
    logic [CNT_W:0] pending;
    pending = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, popping};
    return pending < (CNT_W + 1)'(RSP_DEPTH);
  endfunction

endpackage

// File: rtl/mem_1rw_rsp_fifo.sv
// mem_1rw_rsp_fifo: two-entry in-order response buffer with registered head data.
module mem_1rw_rsp_fifo
  import mem_1rw_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic             notEmpty_o,
  output logic [WIDTH-1:0] headData_o
);

  logic [WIDTH-1:0] mem_q [RSP_DEPTH];
  logic             rdPtr_q, rdPtr_d;
  logic             wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    rdPtr_d = rdPtr_q;
    wrPtr_d = wrPtr_q;
    count_d = count_q;
    if (push_i) wrPtr_d = ~wrPtr_q;
    if (pop_i)  rdPtr_d = ~rdPtr_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is visible.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wrPtr_q] <= pushData_i;
  end

  assign count_o    = count_q;
  assign notEmpty_o = (count_q != '0);
  assign headData_o = mem_q[rdPtr_q];

endmodule

// File: rtl/mem_1rw_arbiter.sv
// mem_1rw_arbiter: merges a write and a read request channel onto the single RW0 port of mem_1rw.
// Define MEM_1RW_ARB_RR_EN for round-robin arbitration; otherwise writes have fixed priority.
module mem_1rw_arbiter #(
  parameter int ADDR_W = mem_1rw_pkg::ADDR_W,
  parameter int DATA_W = mem_1rw_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_clk,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);
  import mem_1rw_pkg::*;

  logic [CNT_W-1:0]  fifoCount;
  logic              fifoNotEmpty;
  logic [DATA_W-1:0] fifoHead;
  logic              pop;
  logic              credit;
  logic              rdEligible;
  logic              inflight_q, inflight_d;
  logic              grantW, grantR;
  grant_e            grant;

  assign pop = fifoNotEmpty && rsp_ready;

  // A response leaving this cycle frees its slot at once, so a steady consumer sees one read per cycle.
  assign credit     = hasCredit(fifoCount, inflight_q, pop);
  assign rdEligible = r_valid && credit;

`ifdef MEM_1RW_ARB_RR_EN
  prio_e prio_q, prio_d;

  always_comb begin
    prio_d = prio_q;
    if (grant == GRANT_R)      prio_d = PRIO_W;
    else if (grant == GRANT_W) prio_d = PRIO_R;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) prio_q <= PRIO_R;
    else          prio_q <= prio_d;
  end
`endif

  // Nothing is granted while reset is held so the RAM sees no traffic.
  always_comb begin
    grant = GRANT_NONE;
    if (reset_n) begin
`ifdef MEM_1RW_ARB_RR_EN
      if (w_valid && rdEligible) grant = (prio_q == PRIO_R) ? GRANT_R : GRANT_W;
      else if (rdEligible)       grant = GRANT_R;
      else if (w_valid)          grant = GRANT_W;
`else
      if (w_valid)         grant = GRANT_W;
      else if (rdEligible) grant = GRANT_R;
`endif
    end
  end

  assign grantW = (grant == GRANT_W);
  assign grantR = (grant == GRANT_R);

  assign w_ready   = grantW;
  assign r_ready   = grantR;
  assign RW0_en    = grantW | grantR;
  assign RW0_wmode = grantW;
  assign RW0_addr  = grantW ? w_addr : r_addr;
  assign RW0_wdata = w_data;
  assign RW0_clk   = clock;

  assign inflight_d = grantR;

  always_ff @(posedge clock) begin
    if (!reset_n) inflight_q <= 1'b0;
    else          inflight_q <= inflight_d;
  end

  mem_1rw_rsp_fifo #(
    .WIDTH(DATA_W)
  ) u_rsp_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_i     (inflight_q),
    .pushData_i (RW0_rdata),
    .pop_i      (pop),
    .count_o    (fifoCount),
    .notEmpty_o (fifoNotEmpty),
    .headData_o (fifoHead)
  );

  assign rsp_valid = fifoNotEmpty;
  assign rsp_data  = fifoHead;

endmodule

// File: tb/tb_mem_1rw_arbiter.sv
// tb_mem_1rw_arbiter: scoreboard bench for mem_1rw_arbiter driving a behavioural 32 x 64 RAM.
// Build with +define+MEM_1RW_ARB_RR_EN to select the round-robin expectations.
module tb_mem_1rw_arbiter;

  localparam int AW = 5;
  localparam int DW = 64;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          w_valid, r_valid, rsp_ready;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] w_data;
  logic          w_ready, r_ready, rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en, RW0_clk, RW0_wmode;
  logic [DW-1:0] RW0_wdata, RW0_rdata;

  mem_1rw_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_addr    (r_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .RW0_addr  (RW0_addr),
    .RW0_en    (RW0_en),
    .RW0_clk   (RW0_clk),
    .RW0_wmode (RW0_wmode),
    .RW0_wdata (RW0_wdata),
    .RW0_rdata (RW0_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;

  rsp_t          expQ[$];
  int            popLog[$];
  logic [DW-1:0] shadow [32];
  logic [DW-1:0] ram [32];
  bit            shadowInit = 1'b0;
  bit            prioW = 1'b0;
  bit            expValid;
  byte           actGrant = "-";
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  function automatic logic [DW-1:0] initWord(input int a);
    return {32'hC0DE_0000 + 32'(a), 32'h0000_1000 + 32'(a * 7)};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Inputs change just after the rising edge; the task returns mid-cycle once the
  // predictor and monitor have sampled, so callers may inspect this cycle's outputs.
  task automatic applyStimulus(input bit rst_n, input bit wv, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input bit rv, input logic [AW-1:0] ra,
                               input bit rr);
    @(posedge clock);
    #1;
    reset_n   = rst_n;
    w_valid   = wv;
    w_addr    = wa;
    w_data    = wd;
    r_valid   = rv;
    r_addr    = ra;
    rsp_ready = rr;
    @(negedge clock);
    #2;
  endtask

  task automatic idle(input bit rr);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, rr);
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 20) begin
      idle(1'b1);
      n++;
    end
    checkOutput("drain", 64'(expQ.size()), 64'd0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " w_ready"}, w_ready, 1'b0);
    checkOutput({tag, " r_ready"}, r_ready, 1'b0);
    checkOutput({tag, " RW0_en"}, RW0_en, 1'b0);
    checkOutput({tag, " RW0_wmode"}, RW0_wmode, 1'b0);
    checkOutput({tag, " rsp_valid"}, rsp_valid, 1'b0);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural single-port RAM with one cycle of read latency.
  initial begin
    for (int i = 0; i < 32; i++) ram[i] = initWord(i);
    RW0_rdata = '0;
    forever begin
      @(posedge clock);
      if (RW0_en) begin
        if (RW0_wmode) ram[RW0_addr] <= RW0_wdata;
        else           RW0_rdata     <= ram[RW0_addr];
      end
    end
  end

  // Predictor: decides the grant from the arbitration rules, checks the request side
  // and pushes the expected read response for every granted read.
  always @(negedge clock) begin : predictor
    bit popNow, credit, rdElig, gW, gR;
    int pending;
    if (!shadowInit) begin
      for (int i = 0; i < 32; i++) shadow[i] = initWord(i);
      shadowInit = 1'b1;
    end
    checkOutput("RW0_clk", RW0_clk, clock);
    if (!reset_n) begin
      expQ.delete();
      prioW = 1'b0;
      actGrant = "-";
      checkOutput("reset w_ready", w_ready, 1'b0);
      checkOutput("reset r_ready", r_ready, 1'b0);
      checkOutput("reset RW0_en", RW0_en, 1'b0);
      checkOutput("reset RW0_wmode", RW0_wmode, 1'b0);
    end else begin
      popNow = 1'b0;
      if (expQ.size() > 0) popNow = (cyc - expQ[0].cyc >= 2) && rsp_ready;
      pending = expQ.size() - (popNow ? 1 : 0);
      credit  = pending < 2;
      rdElig  = r_valid && credit;
      gW = 1'b0;
      gR = 1'b0;
`ifdef MEM_1RW_ARB_RR_EN
      if (w_valid && rdElig) begin
        if (prioW) gW = 1'b1;
        else       gR = 1'b1;
      end else if (w_valid) gW = 1'b1;
      else if (rdElig)      gR = 1'b1;
`else
      if (w_valid)     gW = 1'b1;
      else if (rdElig) gR = 1'b1;
`endif
      checkOutput("w_ready", w_ready, gW);
      checkOutput("r_ready", r_ready, gR);
      checkOutput("RW0_en", RW0_en, gW | gR);
      checkOutput("RW0_wmode", RW0_wmode, gW);
      if (gW) begin
        checkOutput("RW0_addr write", RW0_addr, w_addr);
        checkOutput("RW0_wdata", RW0_wdata, w_data);
        shadow[w_addr] = w_data;
        prioW = 1'b0;
      end
      if (gR) begin
        checkOutput("RW0_addr read", RW0_addr, r_addr);
        expQ.push_back('{data: shadow[r_addr], cyc: cyc});
        prioW = 1'b1;
      end
      actGrant = w_ready ? "W" : (r_ready ? "R" : "-");
    end
  end

  // Monitor: every cycle out of reset, compares the response port with the head of the scoreboard.
  always @(negedge clock) begin : monitor
    #1;
    if (reset_n) begin
      expValid = 1'b0;
      if (expQ.size() > 0) expValid = (cyc - expQ[0].cyc >= 2);
      checkOutput("rsp_valid", rsp_valid, expValid);
      if (expValid) begin
        checkOutput(rsp_ready ? "rsp_data" : "rsp_data stalled", rsp_data, expQ[0].data);
        if (rsp_ready) begin
          void'(expQ.pop_front());
          popLog.push_back(cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [AW-1:0] addrs [4];
    logic [DW-1:0] valA;
    string         expPat;
    int            idx, acc, n, popBase;

    reset_n = 1'b0; w_valid = 1'b0; r_valid = 1'b0; rsp_ready = 1'b0;
    w_addr = '0; r_addr = '0; w_data = '0;

    // Reset with both requests asserted: nothing may be granted.
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 5'd3, 64'hDEAD, 1'b1, 5'd3, 1'b1);
      checkIdleOutputs("in reset");
    end
    idle(1'b1);
    checkIdleOutputs("after reset");

    // Write then read back, response exactly two cycles after the read grant.
    applyStimulus(1'b1, 1'b1, 5'd3, 64'h0123456789ABCDEF, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 1'b1);
    checkOutput("read grant addr3", r_ready, 1'b1);
    idle(1'b1);
    checkOutput("rsp_valid one cycle after grant", rsp_valid, 1'b0);
    idle(1'b1);
    checkOutput("rsp_valid two cycles after grant", rsp_valid, 1'b1);
    checkOutput("rsp_data addr3", rsp_data, 64'h0123456789ABCDEF);
    drain();

    // Top address write followed immediately by its read, then the bottom address untouched.
    valA = 64'hA5A5_5A5A_F00D_BEEF;
    applyStimulus(1'b1, 1'b1, 5'd31, valA, 1'b0, '0, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 5'd31, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 1'b1);
    checkOutput("read grant addr0", r_ready, 1'b1);
    idle(1'b1);
    checkOutput("rsp_data addr31", rsp_data, valA);
    idle(1'b1);
    checkOutput("rsp_data addr0", rsp_data, initWord(0));
    drain();

    // Backpressure: only two reads accepted while the consumer stalls.
    addrs[0] = 5'd5; addrs[1] = 5'd6; addrs[2] = 5'd7; addrs[3] = 5'd8;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, addrs[idx], 1'b0);
      if (r_ready) idx++;
    end
    checkOutput("reads accepted while stalled", 64'(idx), 64'd2);
    checkOutput("r_ready held low while stalled", r_ready, 1'b0);
    popBase = popLog.size();
    n = 0;
    while (idx < 4 && n < 20) begin
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, addrs[idx], 1'b1);
      if (r_ready) idx++;
      n++;
    end
    checkOutput("reads accepted after release", 64'(idx), 64'd4);
    drain();
    checkOutput("responses after release", 64'(popLog.size() - popBase), 64'd4);
    if (popLog.size() - popBase == 4)
      checkOutput("gapless response burst", 64'(popLog[popBase + 3] - popLog[popBase]), 64'd3);

    // Both channels requesting for six cycles from a fresh reset.
`ifdef MEM_1RW_ARB_RR_EN
    expPat = "RWRWRW";
`else
    expPat = "WWWWWW";
`endif
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1, 5'(10 + i), {32'hBEEF_0000, 32'(i)}, 1'b1, 5'(20 + i), 1'b1);
      checkOutput($sformatf("grant order %0d", i), actGrant, expPat[i]);
    end
    drain();

    // Reset one cycle after a read grant discards the in-flight read.
    applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 5'd9, 1'b1);
    checkOutput("read grant before reset", r_ready, 1'b1);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      checkIdleOutputs("post mid-op reset");
    end
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 5'(12 + i), 1'b0);
      if (r_ready) acc++;
    end
    checkOutput("credit after mid-op reset", 64'(acc), 64'd2);
    drain();

    // Randomized traffic with a toggling consumer.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    {$urandom, $urandom}, $urandom_range(0, 3) != 0,
                    5'($urandom_range(0, 31)), $urandom_range(0, 2) != 0);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
